pipe_scoreboard: RTL
====================

# pipe_scoreboard

Parametrised hazard/forwarding scoreboard for the in-order pipelined CPU, replacing fixed EXE/MEM forwarding and load-use stall decode with a depth-generic shadow pipeline. It tracks every in-flight register write from issue (ID→EXE) to writeback. Each cycle it emits, per source operand, the forwarding-source stage index and a single issue stall. It sits beside the ID stage and drives the operand muxes and the PC/IF-ID/ID-EXE stall controls.

## Interface
Parameters:
- DEPTH, 3, number of tracked stages after ID (1 = EXE, 2 = MEM, …, DEPTH = WB); legal range 1–8.
- NUM_SRC, 2, number of source operands checked per issuing instruction.
- AW, 5, register address width.
- SEL_W, $clog2(DEPTH+1), derived width of each forward select and of `inflight`.

Ports:
- clk, input, 1, pipeline clock.
- rst, input, 1, asynchronous, active-high reset.
- hold, input, 1, external freeze (memory wait); no slot advances.
- flush, input, 1, synchronous clear of all slots (exception/redirect).
- issue_valid, input, 1, ID holds a real (non-NOP) instruction.
- issue_we, input, 1, issuing instruction writes a register.
- issue_dst, input, AW, destination register.
- issue_lat, input, SEL_W, first stage index whose combinational output carries the result (1 = ALU, 2 = load).
- src_addr, input, NUM_SRC*AW, packed source register addresses; operand i is at [i*AW +: AW].
- src_used, input, NUM_SRC, per-operand "operand actually read".
- stall, output, 1, issue must not proceed this cycle.
- fwd_sel, output, NUM_SRC*SEL_W, per operand: 0 = register file, k = result from slot k.
- inflight, output, SEL_W, count of valid writing entries in slots 1..DEPTH.

## Operation
- State: slots 1..DEPTH, each holding {v, we, dst, lat}.
- Lat normalisation at capture:
  - lat 0 is stored as 1.
  - lat > DEPTH is stored as DEPTH.
- Advance, on a clock edge with hold=0 and flush=0:
  - slot[k+1] ← slot[k] for k = 1..DEPTH-1.
  - slot[DEPTH] contents retire.
  - slot[1] ← {1, issue_we, issue_dst, lat} when issue_valid && !stall; otherwise slot[1] ← bubble (v=0).
- hold=1: all slots keep their value; the issue is not captured.
- flush=1: all slots are invalidated. flush has priority over hold.
- Match: operand i matches slot k when all of the following hold:
  - src_used[i]=1;
  - slot[k].v=1 and slot[k].we=1;
  - slot[k].dst = src_addr[i];
  - src_addr[i] ≠ 0.
- Priority: the youngest match (smallest k) decides; older matches are ignored.
- For the deciding match of operand i:
  - k ≥ slot.lat → fwd_sel[i] = k, no hazard.
  - k < slot.lat → hazard: stall=1 and fwd_sel[i] = 0.
- With no match, fwd_sel[i] = 0.
- stall = OR of all operand hazards, gated by issue_valid.
- stall is independent of hold. The top level combines them.
- Writes to r0 never match and never cause a stall.
- inflight counts slots with v=1 && we=1. It is a registered count updated on the same edges as the slots.

## Timing
- Reset values (asynchronous): all slots v=0; stall=0; fwd_sel=0; inflight=0.
- stall and fwd_sel are combinational from the slots and the current src/issue inputs. The path is purely combinational, with no added latency.
- A load (lat 2) followed by a dependent instruction gives exactly 1 stall cycle; forwarding from slot 2 follows on the next cycle.
- A dependent lat-L producer directly ahead gives L−1 stall cycles.
- A stalled issue is re-presented by the upstream logic. The scoreboard keeps inserting bubbles until the hazard clears.
- Boundary conditions:
  - Simultaneous issue and retire of the same dst: the new entry is visible from the next edge; the retiring one is gone.
  - rst mid-operation clears everything immediately; the first issue after deassertion is captured normally.
  - issue_valid=0 forces stall=0.

## Test plan
DEPTH=3 for all scenarios.
- ALU chain: issue r3 (lat 1); next cycle operand r3 → stall=0, fwd_sel=1. One cycle later → fwd_sel=2. Then fwd_sel=3. Then fwd_sel=0.
- Load-use: issue r5 (lat 2); next cycle operand r5 → stall=1 for 1 cycle, slot1 bubble inserted. Following cycle → stall=0, fwd_sel=2.
- Youngest priority: r4 written in slots 1 and 2 (both lat 1); read r4 → fwd_sel=1. r0 source with r0 writer in slot 1 → fwd_sel=0, stall=0.
- Hold: with a load in slot 1, hold=1 for 3 cycles → stall stays 1, slots unchanged, inflight=1. After release → stall clears in 1 cycle.
- Flush/reset: 3 writers in flight (inflight=3). Flush → next cycle inflight=0, fwd_sel=0. Assert rst mid-stall → stall=0 immediately.
- Dual operand: src0=r2 (load in slot 1), src1=r7 (ALU in slot 2) → stall=1, fwd_sel1=2. Next cycle → stall=0, fwd_sel0=2, fwd_sel1=3.

Source files
------------

// File: rtl/pipe_scoreboard_if.sv
// pipe_scoreboard_if: issue/operand/stall bundle between the ID stage and the hazard scoreboard.
interface pipe_scoreboard_if #(
    parameter int DEPTH   = 3,
    parameter int NUM_SRC = 2,
    parameter int AW      = 5,
    parameter int SEL_W   = $clog2(DEPTH + 1)
);
    logic                     hold;
    logic                     flush;
    logic                     issue_valid;
    logic                     issue_we;
    logic [AW-1:0]            issue_dst;
    logic [SEL_W-1:0]         issue_lat;
    logic [NUM_SRC*AW-1:0]    src_addr;
    logic [NUM_SRC-1:0]       src_used;
    logic                     stall;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic [SEL_W-1:0]         inflight;

    modport master (
        output hold, flush, issue_valid, issue_we, issue_dst, issue_lat, src_addr, src_used,
        input  stall, fwd_sel, inflight
    );

    modport slave (
        input  hold, flush, issue_valid, issue_we, issue_dst, issue_lat, src_addr, src_used,
        output stall, fwd_sel, inflight
    );
endinterface

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: shadow pipeline of in-flight register writes driving operand forwarding and issue stall.
module pipe_scoreboard #(
    parameter int DEPTH   = 3,
    parameter int NUM_SRC = 2,
    parameter int AW      = 5,
    parameter int SEL_W   = $clog2(DEPTH + 1)
) (
    input logic              clk,
    input logic              rst,
    pipe_scoreboard_if.slave sb
);
    logic [DEPTH:1]   v, we, nv, nw;
    logic [AW-1:0]    dst [1:DEPTH];
    logic [AW-1:0]    nd  [1:DEPTH];
    logic [SEL_W-1:0] lat [1:DEPTH];
    logic [SEL_W-1:0] nl  [1:DEPTH];
    logic [SEL_W-1:0] sel [NUM_SRC];
    logic [NUM_SRC-1:0] haz;
    logic [SEL_W-1:0] cap_lat, cnt, inflight_q;

    assign cap_lat = sb.issue_lat == '0 ? SEL_W'(1) :
                     sb.issue_lat > SEL_W'(DEPTH) ? SEL_W'(DEPTH) : sb.issue_lat;

    // descending scan so the youngest (smallest k) match is the last one written
    always_comb begin
        haz = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sel[i] = '0;
            for (int k = DEPTH; k >= 1; k--)
                if (sb.src_used[i] && v[k] && we[k] && sb.src_addr[i*AW +: AW] != '0 &&
                    dst[k] == sb.src_addr[i*AW +: AW]) begin
                    haz[i] = SEL_W'(k) < lat[k];
                    sel[i] = SEL_W'(k) < lat[k] ? '0 : SEL_W'(k);
                end
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
        assign sb.fwd_sel[g*SEL_W +: SEL_W] = sel[g];
    end

    assign sb.stall    = sb.issue_valid && |haz;
    assign sb.inflight = inflight_q;

    always_comb begin
        nv = v;
        nw = we;
        nd = dst;
        nl = lat;
        if (sb.flush) begin
            nv = '0;
        end else if (!sb.hold) begin
            for (int k = DEPTH; k > 1; k--) begin
                nv[k] = v[k-1];
                nw[k] = we[k-1];
                nd[k] = dst[k-1];
                nl[k] = lat[k-1];
            end
            nv[1] = sb.issue_valid && !sb.stall;
            nw[1] = sb.issue_we;
            nd[1] = sb.issue_dst;
            nl[1] = cap_lat;
        end
        cnt = '0;
        for (int k = 1; k <= DEPTH; k++)
            cnt = cnt + SEL_W'(nv[k] & nw[k]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v          <= '0;
            we         <= '0;
            dst        <= '{default: '0};
            lat        <= '{default: '0};
            inflight_q <= '0;
        end else begin
            v          <= nv;
            we         <= nw;
            dst        <= nd;
            lat        <= nl;
            inflight_q <= cnt;
        end
    end
endmodule
